quat_integrator_ctrl: RTL and testbench
=======================================

Name: quat_integrator_ctrl

Overview:
Sequencer for the attitude-integration loop. It accepts gyro samples over a valid/ready handshake and drives the IMU-to-delta-quaternion stage. It then feeds the current attitude quaternion and the delta quaternion into the pipelined quaternion multiplier, waits out each stage's fixed latency, and writes the product back to the state as Q15 with saturation. It owns the attitude state register and sits between the sensor front end and the downstream attitude consumers.

Parameters:
DELTA_LAT, 2, cycles from stable gyro/dt at delta stage input to valid dq0..dq3 (>=1)
MULT_LAT, 4, cycles from stable multiplier operands to valid r1..r4 (>=1)
CNT_W, 4, width of internal wait counter; must hold max(DELTA_LAT,MULT_LAT)-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
q_clear  in  1  synchronous re-initialise of attitude to identity
s_valid  in  1  gyro sample valid
s_ready  out  1  controller can accept a sample
wx, wy, wz  in  16 signed each  angular rate sample
dt  in  32  integration step
dp_wx, dp_wy, dp_wz  out  16 signed each  registered rates to delta stage
dp_dt  out  32  registered dt to delta stage
dq0..dq3  in  16 signed each  delta quaternion from delta stage, Q15
mul_a1, mul_b1, mul_c1, mul_d1  out  16 signed each  current attitude q0..q3 to multiplier
mul_a2, mul_b2, mul_c2, mul_d2  out  16 signed each  latched dq0..dq3 to multiplier
mul_r1..mul_r4  in  32 signed each  multiplier product, Q30
q0..q3  out  16 signed each  attitude state, Q15
q_valid  out  1  one-cycle pulse: q0..q3 just updated
busy  out  1  high in DELTA_WAIT or MULT_WAIT
sat_flag  out  1  sticky: a write-back saturated
sample_cnt  out  16  completed updates, wraps 65535->0

Behaviour:
- Reset and q_clear produce the same state:
  - q0..q3 = 32767,0,0,0.
  - dp_* = 0, mul_*2 = 0, q_valid = 0, sat_flag = 0, sample_cnt = 0.
  - State = IDLE, so s_ready = 1.
- q_clear has priority over all other activity. Asserted mid-operation, it aborts the in-flight sample with no write-back and no q_valid.
- States: IDLE, DELTA_WAIT, MULT_WAIT. s_ready = (state==IDLE). busy = !s_ready.
- IDLE:
  - On s_valid && s_ready at edge E0, register wx/wy/wz/dt into dp_*.
  - Load cnt = DELTA_LAT-1 and go to DELTA_WAIT.
  - dp_* hold until the next accept.
- DELTA_WAIT:
  - cnt decrements each cycle.
  - At the edge where cnt==0, latch dq0..dq3 into mul_*2, load cnt = MULT_LAT-1, go to MULT_WAIT.
- MULT_WAIT:
  - mul_*1 (the q registers) and mul_*2 are held stable.
  - At the edge where cnt==0, write back q, pulse q_valid, increment sample_cnt, go to IDLE.
  - Write-back per lane: qk = r[30:15] if r[31]==r[30]; otherwise saturate to 32767 (r[31]=0) or -32768 (r[31]=1) and set sat_flag.
- Timing:
  - Update edge = E0 + DELTA_LAT + MULT_LAT. q_valid is high for exactly the following cycle.
  - s_ready is high in that same cycle, so a sample presented then is accepted.
  - Maximum throughput is one sample per DELTA_LAT+MULT_LAT+1 cycles.
- s_valid while busy is ignored: no accept. The source must hold the sample until it sees s_ready.
- Inputs wx/wy/wz/dt may change freely after acceptance. Only dp_* are seen by the datapath.
- q_clear and rst asserted together: identical result.
- sat_flag clears only on rst or q_clear.

Test Plan:
- Reset: rst high 3 cycles, then low -> q=(32767,0,0,0), s_ready=1, busy=0, q_valid=0, sample_cnt=0.
- Latency and value:
  - Stimulus: stub delta returns dq=(32767,1000,0,0); stub multiplier computes the Hamilton product with default latencies; one sample wx=15000, dt=100000.
  - Response: q_valid exactly 6 cycles after the accept edge, q=(32766,999,0,0), sample_cnt=1.
- Handshake: hold s_valid high continuously -> accepts spaced exactly 7 cycles apart; s_ready low for 6 cycles after each accept; dp_wx changes only at accept edges.
- Saturation:
  - Multiplier stub forces r1=32'h4000_0000 -> q0=32767, sat_flag=1.
  - Next sample with r1=32'hBFFF_FFFF -> q0=-32768.
  - sat_flag stays 1 until q_clear, then reads 0.
- Abort: assert q_clear for 1 cycle during MULT_WAIT -> no q_valid pulse, q=(32767,0,0,0), s_ready=1 the next cycle; a following sample completes normally.
- Wrap: preload sample_cnt near 65535 via 65536 forced updates (or a short-latency parameterisation) -> sample_cnt wraps to 0 with no side effects.

Source files
------------

// File: rtl/quat_integrator_ctrl.sv
// Attitude-integration sequencer: accepts a gyro sample, waits on the delta-quaternion stage,
// multiplies into the attitude state, and writes the Q30 product back as saturated Q15.
module quat_integrator_ctrl #(
    parameter int unsigned DELTA_LAT = 2,
    parameter int unsigned MULT_LAT  = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_clear,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [15:0] wx,
    input  logic signed [15:0] wy,
    input  logic signed [15:0] wz,
    input  logic        [31:0] dt,
    output logic signed [15:0] dp_wx,
    output logic signed [15:0] dp_wy,
    output logic signed [15:0] dp_wz,
    output logic        [31:0] dp_dt,
    input  logic signed [15:0] dq0,
    input  logic signed [15:0] dq1,
    input  logic signed [15:0] dq2,
    input  logic signed [15:0] dq3,
    output logic signed [15:0] mul_a1,
    output logic signed [15:0] mul_b1,
    output logic signed [15:0] mul_c1,
    output logic signed [15:0] mul_d1,
    output logic signed [15:0] mul_a2,
    output logic signed [15:0] mul_b2,
    output logic signed [15:0] mul_c2,
    output logic signed [15:0] mul_d2,
    input  logic signed [31:0] mul_r1,
    input  logic signed [31:0] mul_r2,
    input  logic signed [31:0] mul_r3,
    input  logic signed [31:0] mul_r4,
    output logic signed [15:0] q0,
    output logic signed [15:0] q1,
    output logic signed [15:0] q2,
    output logic signed [15:0] q3,
    output logic               q_valid,
    output logic               busy,
    output logic               sat_flag,
    output logic        [15:0] sample_cnt
);

    typedef enum logic [1:0] {StIdle, StDeltaWait, StMultWait} state_e;

    localparam logic [CNT_W-1:0] DeltaLoad = CNT_W'(DELTA_LAT - 1);
    localparam logic [CNT_W-1:0] MultLoad  = CNT_W'(MULT_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0][15:0]  dp_w_q;
    logic [31:0]       dp_dt_q;
    logic [3:0][15:0]  dq_q;
    logic [3:0][15:0]  q_q;
    logic [3:0][15:0]  q_wb;
    logic [3:0][31:0]  r_in;
    logic [3:0]        lane_sat;
    logic              q_valid_q;
    logic              sat_flag_q;
    logic [15:0]       sample_cnt_q;
    logic              accept, dq_latch, write_back;

    // Q30 -> Q15: keep r[30:15] unless bits 31/30 disagree, meaning the value left Q15 range.
    function automatic logic [15:0] sat_q15(input logic [31:0] r);
        if (r[31] == r[30]) return r[30:15];
        else if (r[31])     return 16'h8000;
        else                return 16'h7fff;
    endfunction

    assign r_in = {mul_r4, mul_r3, mul_r2, mul_r1};

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            q_wb[k]     = sat_q15(r_in[k]);
            lane_sat[k] = r_in[k][31] ^ r_in[k][30];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        dq_latch   = 1'b0;
        write_back = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_valid) begin
                    accept  = 1'b1;
                    state_d = StDeltaWait;
                    cnt_d   = DeltaLoad;
                end
            end
            StDeltaWait: begin
                if (cnt_q == '0) begin
                    dq_latch = 1'b1;
                    state_d  = StMultWait;
                    cnt_d    = MultLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StMultWait: begin
                if (cnt_q == '0) begin
                    write_back = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // q_clear shares the reset path so an in-flight sample is dropped without write-back.
    always_ff @(posedge clk) begin
        if (rst || q_clear) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            dp_w_q       <= '0;
            dp_dt_q      <= '0;
            dq_q         <= '0;
            q_q          <= {16'h0000, 16'h0000, 16'h0000, 16'h7fff};
            q_valid_q    <= 1'b0;
            sat_flag_q   <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_valid_q <= write_back;
            if (accept) begin
                dp_w_q  <= {wz, wy, wx};
                dp_dt_q <= dt;
            end
            if (dq_latch) begin
                dq_q <= {dq3, dq2, dq1, dq0};
            end
            if (write_back) begin
                q_q          <= q_wb;
                sample_cnt_q <= sample_cnt_q + 16'd1;
                sat_flag_q   <= sat_flag_q | (|lane_sat);
            end
        end
    end

    assign s_ready    = (state_q == StIdle);
    assign busy       = ~s_ready;
    assign dp_wx      = dp_w_q[0];
    assign dp_wy      = dp_w_q[1];
    assign dp_wz      = dp_w_q[2];
    assign dp_dt      = dp_dt_q;
    assign mul_a1     = q_q[0];
    assign mul_b1     = q_q[1];
    assign mul_c1     = q_q[2];
    assign mul_d1     = q_q[3];
    assign mul_a2     = dq_q[0];
    assign mul_b2     = dq_q[1];
    assign mul_c2     = dq_q[2];
    assign mul_d2     = dq_q[3];
    assign q0         = q_q[0];
    assign q1         = q_q[1];
    assign q2         = q_q[2];
    assign q3         = q_q[3];
    assign q_valid    = q_valid_q;
    assign sat_flag   = sat_flag_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_quat_integrator_ctrl.sv
// Directed bench for quat_integrator_ctrl with a constant delta-stage stub and a pipelined
// Hamilton-product multiplier stub whose r1 lane can be overridden.
module tb_quat_integrator_ctrl;

    logic               clk = 1'b0;
    logic               rst, q_clear, s_valid, s_ready;
    logic signed [15:0] wx, wy, wz;
    logic        [31:0] dt;
    logic signed [15:0] dp_wx, dp_wy, dp_wz;
    logic        [31:0] dp_dt;
    logic signed [15:0] dq0, dq1, dq2, dq3;
    logic signed [15:0] mul_a1, mul_b1, mul_c1, mul_d1;
    logic signed [15:0] mul_a2, mul_b2, mul_c2, mul_d2;
    logic signed [31:0] mul_r1, mul_r2, mul_r3, mul_r4;
    logic signed [15:0] q0, q1, q2, q3;
    logic               q_valid, busy, sat_flag;
    logic        [15:0] sample_cnt;

    int total = 0;
    int bad   = 0;

    logic        r1_force;
    logic [31:0] r1_val;
    logic [3:0][31:0] stg0, stg1, stg2;

    always #5 clk = ~clk;

    quat_integrator_ctrl dut (
        .clk(clk), .rst(rst), .q_clear(q_clear), .s_valid(s_valid), .s_ready(s_ready),
        .wx(wx), .wy(wy), .wz(wz), .dt(dt),
        .dp_wx(dp_wx), .dp_wy(dp_wy), .dp_wz(dp_wz), .dp_dt(dp_dt),
        .dq0(dq0), .dq1(dq1), .dq2(dq2), .dq3(dq3),
        .mul_a1(mul_a1), .mul_b1(mul_b1), .mul_c1(mul_c1), .mul_d1(mul_d1),
        .mul_a2(mul_a2), .mul_b2(mul_b2), .mul_c2(mul_c2), .mul_d2(mul_d2),
        .mul_r1(mul_r1), .mul_r2(mul_r2), .mul_r3(mul_r3), .mul_r4(mul_r4),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .q_valid(q_valid), .busy(busy), .sat_flag(sat_flag), .sample_cnt(sample_cnt)
    );

    function automatic int mul(input logic signed [15:0] a, input logic signed [15:0] b);
        return int'(a) * int'(b);
    endfunction

    // Three registers: operands stable from edge N give a valid result sampled at edge N+4.
    always @(posedge clk) begin
        stg0[0] <= mul(mul_a1, mul_a2) - mul(mul_b1, mul_b2) - mul(mul_c1, mul_c2)
                 - mul(mul_d1, mul_d2);
        stg0[1] <= mul(mul_a1, mul_b2) + mul(mul_b1, mul_a2) + mul(mul_c1, mul_d2)
                 - mul(mul_d1, mul_c2);
        stg0[2] <= mul(mul_a1, mul_c2) - mul(mul_b1, mul_d2) + mul(mul_c1, mul_a2)
                 + mul(mul_d1, mul_b2);
        stg0[3] <= mul(mul_a1, mul_d2) + mul(mul_b1, mul_c2) - mul(mul_c1, mul_b2)
                 + mul(mul_d1, mul_a2);
        stg1 <= stg0;
        stg2 <= stg1;
    end

    assign mul_r1 = r1_force ? r1_val : stg2[0];
    assign mul_r2 = stg2[1];
    assign mul_r3 = stg2[2];
    assign mul_r4 = stg2[3];

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample, let it be accepted, then wait (bounded) for the q_valid pulse.
    task automatic send_sample(input logic signed [15:0] w, input logic [31:0] step);
        int lat;
        check_eq("ready_before_send", s_ready, 1);
        wx = w;
        dt = step;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (q_valid) break;
        end
        check_eq("update_latency", lat, 6);
    endtask

    task automatic pulse_clear();
        q_clear = 1'b1;
        tick();
        q_clear = 1'b0;
    endtask

    initial begin
        int exp_dp;
        int pulses;
        int waited;

        rst = 1'b1; q_clear = 1'b0; s_valid = 1'b0;
        wx = '0; wy = '0; wz = '0; dt = '0;
        dq0 = 16'sd32767; dq1 = 16'sd1000; dq2 = '0; dq3 = '0;
        r1_force = 1'b0; r1_val = '0;
        repeat (3) tick();
        rst = 1'b0;

        check_eq("rst_q0", q0, 32767);
        check_eq("rst_q1", q1, 0);
        check_eq("rst_q2", q2, 0);
        check_eq("rst_q3", q3, 0);
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_q_valid", q_valid, 0);
        check_eq("rst_sample_cnt", sample_cnt, 0);
        check_eq("rst_sat_flag", sat_flag, 0);
        check_eq("rst_dp_wx", dp_wx, 0);
        check_eq("rst_mul_a2", mul_a2, 0);

        // Single sample: identity * (32767,1000,0,0) -> (32766,999,0,0).
        wy = -16'sd7;
        wz = 16'sd9;
        send_sample(16'sd15000, 32'd100000);
        check_eq("lat_q0", q0, 32766);
        check_eq("lat_q1", q1, 999);
        check_eq("lat_q2", q2, 0);
        check_eq("lat_q3", q3, 0);
        check_eq("lat_cnt", sample_cnt, 1);
        check_eq("lat_ready", s_ready, 1);
        check_eq("lat_dp_wx", dp_wx, 15000);
        check_eq("lat_dp_wy", dp_wy, -7);
        check_eq("lat_dp_wz", dp_wz, 9);
        check_eq("lat_dp_dt", dp_dt, 100000);
        check_eq("lat_mul_a2", mul_a2, 32767);
        check_eq("lat_mul_b2", mul_b2, 1000);
        check_eq("lat_sat", sat_flag, 0);
        tick();
        check_eq("q_valid_one_cycle", q_valid, 0);

        // Back-to-back: s_valid held high, wx changes every cycle.
        exp_dp = 15000;
        s_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            wx = 16'(200 + c);
            check_eq("hs_s_ready", s_ready, ((c % 7) == 0) ? 1 : 0);
            if ((c % 7) == 0) exp_dp = 200 + c;
            tick();
            check_eq("hs_dp_wx", dp_wx, exp_dp);
        end
        s_valid = 1'b0;
        waited = 0;
        while (!s_ready && waited < 20) begin
            tick();
            waited++;
        end
        check_eq("hs_drain", s_ready, 1);
        check_eq("hs_cnt", sample_cnt, 6);

        // Saturation on the r1 lane, both polarities; flag is sticky until q_clear.
        pulse_clear();
        check_eq("clr_q0", q0, 32767);
        check_eq("clr_cnt", sample_cnt, 0);
        r1_force = 1'b1;
        r1_val   = 32'h4000_0000;
        send_sample(16'sd1, 32'd1);
        check_eq("satp_q0", q0, 32767);
        check_eq("satp_q1", q1, 999);
        check_eq("satp_flag", sat_flag, 1);
        r1_val = 32'hBFFF_FFFF;
        tick();
        send_sample(16'sd2, 32'd1);
        check_eq("satn_q0", q0, -32768);
        check_eq("satn_q1", q1, 1998);
        check_eq("satn_flag", sat_flag, 1);
        repeat (3) tick();
        check_eq("sat_sticky", sat_flag, 1);
        r1_force = 1'b0;
        pulse_clear();
        check_eq("sat_cleared", sat_flag, 0);
        check_eq("sat_clr_q0", q0, 32767);

        // Abort during MULT_WAIT.
        wx = 16'sd3;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (3) tick();
        check_eq("abort_busy", busy, 1);
        pulse_clear();
        check_eq("abort_ready", s_ready, 1);
        check_eq("abort_q0", q0, 32767);
        check_eq("abort_q1", q1, 0);
        check_eq("abort_cnt", sample_cnt, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (q_valid) pulses++;
            tick();
        end
        check_eq("abort_no_pulse", pulses, 0);
        send_sample(16'sd4, 32'd5);
        check_eq("post_abort_q0", q0, 32766);
        check_eq("post_abort_q1", q1, 999);
        check_eq("post_abort_cnt", sample_cnt, 1);

        // A few more updates advance the counter.
        for (int i = 0; i < 3; i++) begin
            tick();
            send_sample(16'(10 + i), 32'd7);
        end
        check_eq("cnt_after_four", sample_cnt, 4);

        // rst and q_clear together.
        rst = 1'b1;
        q_clear = 1'b1;
        tick();
        rst = 1'b0;
        q_clear = 1'b0;
        check_eq("both_q0", q0, 32767);
        check_eq("both_q1", q1, 0);
        check_eq("both_cnt", sample_cnt, 0);
        check_eq("both_dp_wx", dp_wx, 0);
        check_eq("both_mul_b2", mul_b2, 0);
        check_eq("both_ready", s_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
